// File: rtl/alu_exec_unit_if.sv
// Execute-unit handshake bundle: operation request in, result response out.
interface alu_exec_unit_if #(
    parameter int WIDTH = 64
);
    // request side
    logic             InValid;
    logic             InReady;
    logic [1:0]       ALUop;
    logic [10:0]      Opcode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;

    // response side
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic [3:0]       ALUCtrl;

    // issuing side (decode/dispatch logic or a testbench)
    modport master (
        output InValid, ALUop, Opcode, A, B, OutReady,
        input  InReady, OutValid, Result, Zero, ALUCtrl
    );

    // the execute unit itself
    modport slave (
        input  InValid, ALUop, Opcode, A, B, OutReady,
        output InReady, OutValid, Result, Zero, ALUCtrl
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-control decode, registered single-cycle ALU, iterative
// shift-add multiplier, valid/ready on both the operation and result sides.
module alu_exec_unit #(
    parameter  int WIDTH = 64,
    localparam int SHW   = $clog2(WIDTH)
) (
    input logic             CLK,
    input logic             Reset,
    alu_exec_unit_if.slave  bus
);

    // ALU control codes
    localparam logic [3:0] C_AND   = 4'b0000;
    localparam logic [3:0] C_ORR   = 4'b0001;
    localparam logic [3:0] C_ADD   = 4'b0010;
    localparam logic [3:0] C_ILL   = 4'b0011;
    localparam logic [3:0] C_SUB   = 4'b0110;
    localparam logic [3:0] C_PASSB = 4'b0111;
    localparam logic [3:0] C_MUL   = 4'b1000;
    localparam logic [3:0] C_LSL   = 4'b1001;
    localparam logic [3:0] C_LSR   = 4'b1010;

    // R-type opcodes, instruction bits [31:21]
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [9:0]  OP_ORRI = 10'b1011001000;   // immediate form, bit 21 is don't-care
    localparam logic [10:0] OP_MUL  = 11'b10011011000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;

    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    typedef enum logic [0:0] {S_IDLE, S_MULT} state_t;

    // payload of the output register
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic [3:0]       ctrl;
    } res_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW:0]     cnt_q, cnt_d;
    res_t             out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic [3:0]       dec_ctrl;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] step_acc;
    logic             accept;

    // Reset gates readiness so nothing is accepted on a reset edge.
    assign bus.InReady = (state_q == S_IDLE) && (!out_valid_q || bus.OutReady) && !Reset;
    assign accept      = bus.InValid && bus.InReady;

    assign bus.OutValid = out_valid_q;
    assign bus.Result   = out_q.result;
    assign bus.Zero     = out_q.zero;
    assign bus.ALUCtrl  = out_q.ctrl;

    // ALU-control decode of the presented operation
    always_comb begin
        dec_ctrl = C_ILL;
        case (bus.ALUop)
            2'b00: dec_ctrl = C_ADD;
            2'b01: dec_ctrl = C_PASSB;
            2'b10: begin
                if (bus.Opcode == OP_ADD)                                    dec_ctrl = C_ADD;
                else if (bus.Opcode == OP_SUB)                               dec_ctrl = C_SUB;
                else if (bus.Opcode == OP_AND)                               dec_ctrl = C_AND;
                else if (bus.Opcode == OP_ORR || bus.Opcode[10:1] == OP_ORRI) dec_ctrl = C_ORR;
                else if (bus.Opcode == OP_MUL)                               dec_ctrl = C_MUL;
                else if (bus.Opcode == OP_LSL)                               dec_ctrl = C_LSL;
                else if (bus.Opcode == OP_LSR)                               dec_ctrl = C_LSR;
                else                                                         dec_ctrl = C_ILL;
            end
            default: dec_ctrl = C_ILL;
        endcase
    end

    // Single-cycle datapath; MUL and illegal codes produce 0 here (MUL goes iterative)
    always_comb begin
        shamt   = bus.B[SHW-1:0];
        alu_res = '0;
        case (dec_ctrl)
            C_ADD:   alu_res = bus.A + bus.B;
            C_SUB:   alu_res = bus.A - bus.B;
            C_AND:   alu_res = bus.A & bus.B;
            C_ORR:   alu_res = bus.A | bus.B;
            C_PASSB: alu_res = bus.B;
            C_LSL:   alu_res = bus.A << shamt;
            C_LSR:   alu_res = bus.A >> shamt;
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Next-state: accept/issue, multiplier stepping, output register load and drain
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        // A transfer empties the register unless a completion below refills it.
        if (out_valid_q && bus.OutReady) out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (dec_ctrl == C_MUL) begin
                        mcand_d  = bus.A;
                        mplier_d = bus.B;
                        acc_d    = '0;
                        cnt_d    = CNT_INIT;
                        state_d  = S_MULT;
                    end else begin
                        out_d.result = alu_res;
                        out_d.zero   = (alu_res == '0);
                        out_d.ctrl   = dec_ctrl;
                        out_valid_d  = 1'b1;
                    end
                end
            end
            S_MULT: begin
                acc_d    = step_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_ONE;
                // Last step: the output register is already empty since accept required a drain.
                if (cnt_q == CNT_ONE) begin
                    out_d.result = step_acc;
                    out_d.zero   = (step_acc == '0);
                    out_d.ctrl   = C_MUL;
                    out_valid_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset aborts any in-flight multiply
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed literal cases plus random
// traffic compared every cycle against a transaction-level model.
module tb_alu_exec_unit;

    localparam int W  = 64;
    localparam int SW = $clog2(W);

    localparam logic [10:0] O_ADD = 11'b10001011000;
    localparam logic [10:0] O_SUB = 11'b11001011000;
    localparam logic [10:0] O_AND = 11'b10001010000;
    localparam logic [10:0] O_ORR = 11'b10101010000;
    localparam logic [10:0] O_MUL = 11'b10011011000;
    localparam logic [10:0] O_LSL = 11'b11010011011;
    localparam logic [10:0] O_LSR = 11'b11010011010;

    logic CLK = 1'b0;
    logic Reset;

    alu_exec_unit_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit rnd_done = 1'b0;

    // model state: visible output register plus a pending multiply
    bit          m_ov    = 1'b0;
    logic [63:0] m_res   = '0;
    bit          m_zero  = 1'b0;
    logic [3:0]  m_ctrl  = '0;
    bit          m_pend  = 1'b0;
    longint      m_done  = 0;
    logic [63:0] m_pres  = '0;
    longint      m_edge  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Architectural meaning of each operation, in plain arithmetic.
    function automatic void ref_op(input logic [1:0] op, input logic [10:0] opc,
                                   input logic [63:0] a, input logic [63:0] b,
                                   output logic [3:0] c, output logic [63:0] r, output bit mul);
        logic [63:0] p2;
        p2  = 64'd1 << b[SW-1:0];
        mul = 1'b0;
        c   = 4'd3;
        r   = '0;
        if (op == 2'b00) begin c = 4'd2; r = a + b; end
        else if (op == 2'b01) begin c = 4'd7; r = b; end
        else if (op == 2'b10) begin
            if (opc == O_ADD)                              begin c = 4'd2; r = a + b; end
            else if (opc == O_SUB)                         begin c = 4'd6; r = a - b; end
            else if (opc == O_AND)                         begin c = 4'd0; r = a & b; end
            else if (opc == O_ORR || opc[10:1] == 10'b1011001000) begin c = 4'd1; r = a | b; end
            else if (opc == O_MUL)                         begin c = 4'd8; r = a * b; mul = 1'b1; end
            else if (opc == O_LSL)                         begin c = 4'd9; r = a * p2; end
            else if (opc == O_LSR)                         begin c = 4'd10; r = a / p2; end
        end
    endfunction

    // Compare on the falling edge, then advance the model across the next rising edge.
    always @(negedge CLK) begin
        bit          exp_rdy, acc, mul;
        logic [3:0]  c;
        logic [63:0] r;
        if (chk_en) begin
            exp_rdy = !m_pend && (!m_ov || bus.OutReady) && !Reset;
            chk("OutValid", bus.OutValid, m_ov);
            chk("Result",   bus.Result,   m_res);
            chk("Zero",     bus.Zero,     m_zero);
            chk("ALUCtrl",  bus.ALUCtrl,  m_ctrl);
            chk("InReady",  bus.InReady,  exp_rdy);
            m_edge++;
            if (Reset) begin
                m_ov = 0; m_res = '0; m_zero = 0; m_ctrl = '0; m_pend = 0;
            end else begin
                acc = bus.InValid && exp_rdy;
                if (m_ov && bus.OutReady) m_ov = 0;
                if (m_pend && m_edge == m_done) begin
                    m_pend = 0; m_ov = 1; m_res = m_pres; m_zero = (m_pres == 0); m_ctrl = 4'd8;
                end
                if (acc) begin
                    ref_op(bus.ALUop, bus.Opcode, bus.A, bus.B, c, r, mul);
                    if (mul) begin
                        m_pend = 1; m_done = m_edge + W; m_pres = r;
                    end else begin
                        m_ov = 1; m_res = r; m_zero = (r == 0); m_ctrl = c;
                    end
                end
            end
        end
    end

    // Present an op from just after a rising edge and hold it until accepted.
    task automatic issue(input logic [1:0] op, input logic [10:0] opc,
                         input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        bus.ALUop = op; bus.Opcode = opc; bus.A = a; bus.B = b; bus.InValid = 1'b1;
        @(negedge CLK);
        while (!bus.InReady && n < 300) begin
            n++;
            @(negedge CLK);
        end
        if (!bus.InReady) begin
            checks++; errors++;
            $display("FAIL accept_timeout got=waited %0d cycles expected=InReady", n);
        end
        @(posedge CLK);
        #1;
        bus.InValid = 1'b0;
    endtask

    // Count falling edges until OutValid, bounded.
    task automatic wait_out(output int k);
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!bus.OutValid && k < 300);
    endtask

    initial begin
        int k;
        Reset = 1'b1;
        bus.InValid = 0; bus.ALUop = 0; bus.Opcode = 0; bus.A = 0; bus.B = 0; bus.OutReady = 1'b1;
        @(posedge CLK); #1 chk_en = 1'b1;
        @(posedge CLK); #1;
        chk("rst_outvalid", bus.OutValid, 0);
        chk("rst_result",   bus.Result,   0);
        chk("rst_ctrl",     bus.ALUCtrl,  0);
        chk("rst_inready",  bus.InReady,  0);
        Reset = 1'b0;

        // ADD then back-to-back SUB
        issue(2'b10, O_ADD, 64'd5, 64'd7);
        chk("add_ov", bus.OutValid, 1); chk("add_res", bus.Result, 64'd12);
        chk("add_zero", bus.Zero, 0);   chk("add_ctrl", bus.ALUCtrl, 4'b0010);
        issue(2'b10, O_SUB, 64'd3, 64'd5);
        chk("sub_res", bus.Result, 64'hFFFF_FFFF_FFFF_FFFE); chk("sub_ctrl", bus.ALUCtrl, 4'b0110);

        // CBZ pass-B and illegal
        issue(2'b01, 11'd0, 64'd77, 64'd0);
        chk("cbz0_res", bus.Result, 0); chk("cbz0_zero", bus.Zero, 1); chk("cbz0_ctrl", bus.ALUCtrl, 4'b0111);
        issue(2'b01, 11'd0, 64'd77, 64'd9);
        chk("cbz9_zero", bus.Zero, 0);
        issue(2'b11, O_ADD, 64'd1, 64'd2);
        chk("ill_ctrl", bus.ALUCtrl, 4'b0011); chk("ill_res", bus.Result, 0); chk("ill_zero", bus.Zero, 1);

        // multiplies
        issue(2'b10, O_MUL, 64'd6, 64'd7);
        chk("mul_ov_early", bus.OutValid, 0);
        bus.A = 64'd1000; bus.B = 64'd1000;   // must not disturb the in-flight MUL
        wait_out(k);
        chk("mul_latency", k, W + 1);
        chk("mul_res", bus.Result, 64'd42); chk("mul_ctrl", bus.ALUCtrl, 4'b1000);
        @(posedge CLK); #1;
        issue(2'b10, O_MUL, 64'h1_0000_0000, 64'h1_0000_0000);
        wait_out(k);
        chk("mul32_res", bus.Result, 0); chk("mul32_zero", bus.Zero, 1);
        @(posedge CLK); #1;

        // shifts
        issue(2'b10, O_LSL, 64'd1, 64'd63);
        chk("lsl_res", bus.Result, 64'h8000_0000_0000_0000);
        issue(2'b10, O_LSR, 64'h8000_0000_0000_0000, 64'd64);
        chk("lsr_res", bus.Result, 64'h8000_0000_0000_0000);
        @(posedge CLK); #1;

        // backpressure then drain with a same-cycle replacement
        bus.OutReady = 1'b0;
        issue(2'b10, O_ORR, 64'hF0, 64'h0F);
        repeat (5) begin
            @(negedge CLK);
            chk("bp_hold", bus.Result, 64'hFF);
            chk("bp_inready", bus.InReady, 0);
        end
        @(posedge CLK); #1;
        bus.OutReady = 1'b1;
        issue(2'b00, 11'd0, 64'd100, 64'd1);
        chk("bp_repl_ov", bus.OutValid, 1); chk("bp_repl_res", bus.Result, 64'd101);

        // reset during a multiply
        issue(2'b10, O_MUL, 64'd3, 64'd5);
        repeat (29) @(posedge CLK);
        #1 Reset = 1'b1;
        @(posedge CLK); #1 Reset = 1'b0;
        chk("rstmul_ov", bus.OutValid, 0); chk("rstmul_res", bus.Result, 0);
        @(negedge CLK);
        chk("rstmul_rdy", bus.InReady, 1);
        @(posedge CLK); #1;
        issue(2'b10, O_ADD, 64'd20, 64'd22);
        chk("post_rst_add", bus.Result, 64'd42);

        // random traffic with random consumer backpressure
        fork
            begin
                while (!rnd_done) begin
                    @(posedge CLK); #1;
                    if (!rnd_done) bus.OutReady = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 250; i++) begin
            logic [1:0]  op;
            logic [10:0] opc;
            logic [63:0] a, b;
            int sel;
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
                bus.A = {$urandom, $urandom}; bus.B = {$urandom, $urandom}; bus.Opcode = 11'($urandom);
            end
            sel = $urandom_range(0, 11);
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 4) == 0) ? 64'd0 : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = 64'(($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15));
            op = 2'b10;
            case (sel)
                0:  opc = O_ADD;
                1:  opc = O_SUB;
                2:  opc = O_AND;
                3:  opc = O_ORR;
                4:  opc = {10'b1011001000, 1'($urandom)};
                5:  opc = O_MUL;
                6:  opc = O_LSL;
                7:  opc = O_LSR;
                8:  begin op = 2'b00; opc = 11'($urandom); end
                9:  begin op = 2'b01; opc = 11'($urandom); end
                10: begin op = 2'b11; opc = O_ADD; end
                default: opc = 11'($urandom);
            endcase
            issue(op, opc, a, b);
        end
        rnd_done = 1'b1;
        @(posedge CLK); #1 bus.OutReady = 1'b1;
        repeat (W + 5) @(posedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
